segre_mem_arbiter: RTL

Shares the single main-memory line port between the instruction cache (reads only) and the data cache (line refills plus dirty-line writebacks). It captures cache requests, serialises them into one outstanding memory transaction at a time, and routes the refill line and completion pulse back to the owning cache. It sits between the two segre_cache instances and the memory model in the core top level.

---
 rtl/segre_mem_arbiter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/segre_mem_arbiter.sv
// Shares the main-memory line port between icache refills, dcache refills and dcache writebacks.
// Define SEGRE_MEM_ARB_PERF_EN to add the perf_*_o event and stall counters.
module segre_mem_arbiter #(
    parameter int unsigned MAX_STARVE = 4,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LINE_BYTES = 16
) (
    input  logic                    clk_i,
    input  logic                    rsn_i,
    input  logic                    ic_rd_i,
    input  logic [ADDR_W-1:0]       ic_addr_i,
    output logic                    ic_rcvd_o,
    input  logic                    dc_rd_i,
    input  logic                    dc_wr_i,
    input  logic [ADDR_W-1:0]       dc_addr_i,
    input  logic [ADDR_W-1:0]       dc_wb_addr_i,
    input  logic [LINE_BYTES*8-1:0] dc_wb_line_i,
    output logic                    dc_rcvd_o,
    output logic [LINE_BYTES*8-1:0] line_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [ADDR_W-1:0]       mem_addr_o,
    output logic [LINE_BYTES*8-1:0] mem_wdata_o,
    input  logic                    mem_ack_i,
    input  logic [LINE_BYTES*8-1:0] mem_rdata_i,
    output logic                    busy_o
`ifdef SEGRE_MEM_ARB_PERF_EN
    ,
    output logic [31:0]             perf_ic_reads_o,
    output logic [31:0]             perf_dc_reads_o,
    output logic [31:0]             perf_wbs_o,
    output logic [31:0]             perf_stall_cycles_o
`endif
);

    localparam int unsigned        LineW     = LINE_BYTES * 8;
    localparam logic [ADDR_W-1:0]  OffMask   = ADDR_W'(LINE_BYTES - 1);
    localparam logic [3:0]         MaxStarve = 4'(MAX_STARVE);

    typedef enum logic [1:0] {StIdle, StMem, StResp} state_e;

    state_e             state_q, state_d;
    logic               owner_ic_q, owner_ic_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LineW-1:0]   wdata_q, wdata_d;
    logic [LineW-1:0]   line_q, line_d;
    logic               wb_valid_q, wb_valid_d;
    logic               wb_inflight_q, wb_inflight_d;
    logic [ADDR_W-1:0]  wb_addr_q, wb_addr_d;
    logic [LineW-1:0]   wb_line_q, wb_line_d;
    logic [3:0]         starve_q, starve_d;
    logic               grant_ic, grant_dc;

    always_comb begin
        state_d       = state_q;
        owner_ic_d    = owner_ic_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        line_d        = line_q;
        wb_valid_d    = wb_valid_q;
        wb_inflight_d = wb_inflight_q;
        wb_addr_d     = wb_addr_q;
        wb_line_d     = wb_line_q;
        grant_ic      = 1'b0;
        grant_dc      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (wb_valid_q) begin
                    state_d       = StMem;
                    owner_ic_d    = 1'b0;
                    we_d          = 1'b1;
                    addr_d        = wb_addr_q & ~OffMask;
                    wdata_d       = wb_line_q;
                    wb_inflight_d = 1'b1;
                end else if (dc_rd_i && (!ic_rd_i || starve_q < MaxStarve)) begin
                    grant_dc   = 1'b1;
                    state_d    = StMem;
                    owner_ic_d = 1'b0;
                    we_d       = 1'b0;
                    addr_d     = dc_addr_i & ~OffMask;
                end else if (ic_rd_i) begin
                    grant_ic   = 1'b1;
                    state_d    = StMem;
                    owner_ic_d = 1'b1;
                    we_d       = 1'b0;
                    addr_d     = ic_addr_i & ~OffMask;
                end
            end
            StMem: begin
                if (mem_ack_i) begin
                    if (we_q) begin
                        state_d       = StIdle;
                        wb_valid_d    = wb_valid_q & ~wb_inflight_q;
                        wb_inflight_d = 1'b0;
                    end else begin
                        line_d  = mem_rdata_i;
                        state_d = StResp;
                    end
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // A new writeback always takes the buffer; the copy being written lives in wdata_q.
        if (dc_wr_i) begin
            wb_valid_d    = 1'b1;
            wb_addr_d     = dc_wb_addr_i;
            wb_line_d     = dc_wb_line_i;
            wb_inflight_d = 1'b0;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!ic_rd_i || grant_ic) begin
            starve_d = '0;
        end else if (grant_dc && starve_q != MaxStarve) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q       <= StIdle;
            owner_ic_q    <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            line_q        <= '0;
            wb_valid_q    <= 1'b0;
            wb_inflight_q <= 1'b0;
            wb_addr_q     <= '0;
            wb_line_q     <= '0;
            starve_q      <= '0;
        end else begin
            state_q       <= state_d;
            owner_ic_q    <= owner_ic_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            line_q        <= line_d;
            wb_valid_q    <= wb_valid_d;
            wb_inflight_q <= wb_inflight_d;
            wb_addr_q     <= wb_addr_d;
            wb_line_q     <= wb_line_d;
            starve_q      <= starve_d;
        end
    end

    assign mem_req_o   = (state_q == StMem);
    assign mem_we_o    = (state_q == StMem) & we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign line_o      = line_q;
    assign ic_rcvd_o   = (state_q == StResp) & owner_ic_q;
    assign dc_rcvd_o   = (state_q == StResp) & ~owner_ic_q;
    assign busy_o      = (state_q != StIdle) | wb_valid_q;

`ifdef SEGRE_MEM_ARB_PERF_EN
    logic [31:0] perf_ic_q, perf_dc_q, perf_wb_q, perf_stall_q;
    logic        ic_waiting, dc_waiting;

    assign ic_waiting = ic_rd_i & ~(state_q == StMem & owner_ic_q);
    assign dc_waiting = (dc_rd_i & ~(state_q == StMem & ~owner_ic_q & ~we_q)) |
                        (wb_valid_q & ~wb_inflight_q);

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            perf_ic_q    <= '0;
            perf_dc_q    <= '0;
            perf_wb_q    <= '0;
            perf_stall_q <= '0;
        end else begin
            if (state_q == StMem && mem_ack_i) begin
                if (we_q)            perf_wb_q <= perf_wb_q + 32'd1;
                else if (owner_ic_q) perf_ic_q <= perf_ic_q + 32'd1;
                else                 perf_dc_q <= perf_dc_q + 32'd1;
            end
            if ((state_q == StIdle || state_q == StMem) && (ic_waiting || dc_waiting)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_ic_reads_o     = perf_ic_q;
    assign perf_dc_reads_o     = perf_dc_q;
    assign perf_wbs_o          = perf_wb_q;
    assign perf_stall_cycles_o = perf_stall_q;
`endif

    // Memory may only complete the transaction it was handed.
    assert property (@(posedge clk_i) disable iff (!rsn_i) mem_ack_i |-> state_q == StMem);
    // A second writeback may only land while the buffered one is being issued.
    assert property (@(posedge clk_i) disable iff (!rsn_i)
        dc_wr_i |-> (!wb_valid_q || wb_inflight_q || state_q == StIdle));

endmodule
